// File: rtl/rca_pkg.sv
// Shared encodings and default sizes for the serial ripple-carry adder.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned SLICE_DEF  = 8;
    localparam int unsigned NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

    // Slice index width; never narrower than one bit so a single-slice build still has a counter.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W_DEF = idx_width(NSLICE_DEF);

endpackage

// File: rtl/rca_serial_adder32_if.sv
// Operand/result bus of the serial adder. The ovf signal exists only with RCA_SERIAL_OVF_EN.
interface rca_serial_adder32_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
`ifdef RCA_SERIAL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b, c0,
`ifdef RCA_SERIAL_OVF_EN
        input  ovf,
`endif
        input  busy, done, s, c
    );

    modport slave (
        input  start, a, b, c0,
`ifdef RCA_SERIAL_OVF_EN
        output ovf,
`endif
        output busy, done, s, c
    );
endinterface

// File: rtl/rca_slice_adder.sv
// N-bit combinational ripple-carry adder built from a chain of full adders.
module rca_slice_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] cy;

    assign cy[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]    = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end

    assign cout = cy[N];
endmodule

// File: rtl/rca_serial_adder32.sv
// Multi-cycle adder: one SLICE-bit chunk per clock through a single slice adder,
// carry held in a register between slices. Optional ovf output via RCA_SERIAL_OVF_EN.
module rca_serial_adder32
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SLICE = SLICE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    rca_serial_adder32_if.slave  bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic               carry, carry_nx;
    logic [WIDTH-1:0]   a_q, a_nx;
    logic [WIDTH-1:0]   b_q, b_nx;
    logic [WIDTH-1:0]   s_q, s_nx;
    logic               c_q, c_nx;
    logic               busy_q, busy_nx;
    logic               done_q, done_nx;
`ifdef RCA_SERIAL_OVF_EN
    logic               ovf_q, ovf_nx;
`endif

    int unsigned        base;
    logic [SLICE-1:0]   slice_a, slice_b, slice_s;
    logic               slice_cout;

    assign base    = 32'(idx) * SLICE;
    assign slice_a = a_q[base +: SLICE];
    assign slice_b = b_q[base +: SLICE];

    rca_slice_adder #(.N(SLICE)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        carry_nx = carry;
        a_nx     = a_q;
        b_nx     = b_q;
        s_nx     = s_q;
        c_nx     = c_q;
`ifdef RCA_SERIAL_OVF_EN
        ovf_nx   = ovf_q;
`endif
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    a_nx     = bus.a;
                    b_nx     = bus.b;
                    carry_nx = bus.c0;
                    idx_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                s_nx[base +: SLICE] = slice_s;
                carry_nx            = slice_cout;
                if (idx == LAST_IDX) begin
                    c_nx     = slice_cout;
`ifdef RCA_SERIAL_OVF_EN
                    // Carry into the MSB recovered from its sum bit, XORed with carry out.
                    ovf_nx   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[SLICE-1] ^ slice_cout;
`endif
                    state_nx = DONE;
                end else begin
                    idx_nx = idx + IDX_W'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef RCA_SERIAL_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            carry  <= carry_nx;
            a_q    <= a_nx;
            b_q    <= b_nx;
            s_q    <= s_nx;
            c_q    <= c_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
`ifdef RCA_SERIAL_OVF_EN
            ovf_q  <= ovf_nx;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.c    = c_q;
`ifdef RCA_SERIAL_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_rca_serial_adder32.sv
// Directed bench for rca_serial_adder32; also checks ovf when RCA_SERIAL_OVF_EN is defined.
module tb_rca_serial_adder32;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    rca_serial_adder32_if #(.WIDTH(32)) bus ();

    rca_serial_adder32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One addition; optionally fires an ignored start mid-RUN. Watches 12 sampled cycles.
    task automatic run_add(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c0, input logic [31:0] exp_s, input logic exp_c,
                           input logic exp_ovf, input bit intrude);
        int lat = 0, ndone = 0, nbusy = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.c0 = c0;
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.c0 = ~c0;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) @(negedge clk);
            if (intrude && i == 2) begin
                bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.c0 = 1'b1;
            end
            if (intrude && i == 3) bus.start = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                if (lat == 0) lat = i;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_ndone"},   64'(ndone), 64'd1);
        check({tag, "_nbusy"},   64'(nbusy), 64'd5);
        check({tag, "_s"},       64'(bus.s), 64'(exp_s));
        check({tag, "_c"},       64'(bus.c), 64'(exp_c));
`ifdef RCA_SERIAL_OVF_EN
        check({tag, "_ovf"},     64'(bus.ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unused ovf expectation in %s", tag);
`endif
    endtask

    initial begin
        int ndone, first, last;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c0 = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_s",    64'(bus.s),    64'd0);
        check("rst_c",    64'(bus.c),    64'd0);
        rst = 1'b0;

        run_add("dec_small", 32'd1000, 32'd10000, 1'b1, 32'd11001, 1'b0, 1'b0, 1'b0);
        run_add("dec_large", 32'd1043500, 32'd10546000, 1'b0, 32'd11589500, 1'b0, 1'b0, 1'b0);
        run_add("slice_cy",  32'h0000_00FF, 32'h1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        run_add("wrap",      32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        run_add("ovf_pos",   32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_add("all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_add("intrude",   32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);

        // Reset landing on the second RUN edge.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'hAAAA_AAAA; bus.b = 32'h5555_5555; bus.c0 = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_s",    64'(bus.s),    64'd0);
        check("midrst_c",    64'(bus.c),    64'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("midrst_nodone", 64'(ndone), 64'd0);
        run_add("post_rst", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        // start held high: accepted every 6 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'hDEAD_BEEF; bus.b = 32'h2152_4110; bus.c0 = 1'b1;
        ndone = 0; first = 0; last = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first == 0) first = i;
                last = i;
                check("b2b_s", 64'(bus.s), 64'h0);
                check("b2b_c", 64'(bus.c), 64'd1);
            end
        end
        bus.start = 1'b0;
        check("b2b_ndone", 64'(ndone), 64'd3);
        check("b2b_first", 64'(first), 64'd5);
        check("b2b_last",  64'(last),  64'd17);
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rca_serial_adder32.md
Name: rca_serial_adder32

Overview:
- Multi-cycle 32-bit adder front end. Latches a/b/c0 on a start pulse and feeds one SLICE-bit chunk per clock through a narrow ripple-carry slice. The inter-slice carry is held in a register.
- Produces the same s/c result as the combinational 32-bit ripple-carry adder, at a fraction of the area and critical path.
- Sits between the operand source (register file / test stimulus) and the result consumer. Signals completion with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand and sum width; must be an integer multiple of SLICE.
- SLICE, 8, bits added per clock; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A; latched on accepted start
- b  input  WIDTH  operand B; latched on accepted start
- c0  input  1  carry-in; latched on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; s/c are valid from this cycle on
- s  output  WIDTH  sum, registered
- c  output  1  carry-out of the MSB, registered

Behaviour:
- Reset: rst high at a rising edge forces the following.
  - state=IDLE, slice index=0, carry reg=0.
  - busy=0, done=0, s=0, c=0, internal operand latches=0.
  - Reset takes priority over every other event, including mid-RUN; a partial result is discarded and no done is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge latches a, b, c0; carry reg=c0; idx=0; go to RUN.
  - RUN: each edge adds slice idx to give {cout, sum_slice} = A[idx] + B[idx] + carry reg.
    - Writes sum_slice into s[idx*SLICE +: SLICE] and sets carry reg=cout.
    - While idx<NSLICE-1: idx++, stay in RUN.
    - On idx==NSLICE-1: c=cout, go to DONE.
  - DONE: done=1 for exactly one cycle, then the next edge returns to IDLE.
- Latency: with start sampled at edge E0, slices are computed at edges E1..E_NSLICE. done is high in the cycle after edge E_NSLICE; that is 4 edges after E0 with defaults.
  - Minimum start-to-start spacing is NSLICE+2 cycles.
- start while busy=1 (RUN or DONE) is ignored. It is neither queued nor corrupting.
- a/b/c0 may change freely after acceptance; only the latched copies are used.
- s bits of not-yet-computed slices hold their previous values during RUN. s/c are defined only once done asserts, and hold until the next accepted start's first slice write.
- Arithmetic is unsigned modulo 2^WIDTH. c is the true carry-out of bit WIDTH-1, so {c,s} == a+b+c0 exactly.
- The slice adder is purely combinational. The only carry path between slices goes through the carry register.

Optional Feature:
- Macro: RCA_SERIAL_OVF_EN.
- Defined: adds output port ovf (1 bit), giving two's-complement overflow.
  - Value is the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, captured on the final slice.
  - Reset to 0; same validity and hold rules as c.
- Undefined: no ovf port and no extra logic. Port list and timing are otherwise identical.

Decomposition:
- Shared package/include rca_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default WIDTH/SLICE constants;
  - a clog2-based index-width constant.
- One sub-module, rca_slice_adder: parameter N (=SLICE); ports a[N], b[N], cin → s[N], cout. Built as a ripple chain of full adders and instantiated once.
- FSM, operand latches and result register stay in the top module.

Test Plan:
- a=1000, b=10000, c0=1, start → done after 4 edges; s=11001, c=0; busy high for 5 cycles.
- a=1043500, b=10546000, c0=0 → s=11589500, c=0. Also a=0x000000FF, b=1, c0=0 → s=0x00000100, carry ripples across a slice boundary.
- a=0xFFFFFFFF, b=0, c0=1 → s=0, c=1. With RCA_SERIAL_OVF_EN: a=0x7FFFFFFF, b=1 → s=0x80000000, c=0, ovf=1.
- start pulse again during RUN with different operands → ignored. The original result completes; exactly one done is seen.
- rst asserted at the second RUN edge → next cycle state=IDLE, s=0, c=0, busy=0, no done. A fresh start then completes correctly.
- Back-to-back: start held high continuously → additions accepted every NSLICE+2 cycles, each producing a single done pulse with the correct result.
